// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the K=7, rate-1/2 Viterbi sequencing controller.
package viterbi_pkg;

   localparam int K        = 7;
   localparam int N_STATES = 64;
   localparam int TAIL     = K - 1;
   localparam int MIN_LEN  = TAIL + 1;
   localparam int SW       = $clog2(N_STATES);

   // Value the path-metric bank loads into every state except 0 on oPmInit.
   localparam int                PM_W   = 8;
   localparam logic [PM_W-1:0]   PM_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_TB
   } state_e;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Handshake, strobe and survivor-memory signals between the controller and the decoder datapath.
interface viterbi_ctrl_if
   import viterbi_pkg::*;
#(
   parameter int AW = 12
) ();

   logic          iStart;
   logic [AW:0]   iLen;
   logic          iValid;
   logic          iA;
   logic          iB;
   logic          iDec;
   logic          oReady;
   logic          oBmA;
   logic          oBmB;
   logic          oPmInit;
   logic          oAcsEn;
   logic          oSmWe;
   logic [AW-1:0] oSmWAddr;
   logic          oSmRe;
   logic [AW-1:0] oSmRAddr;
   logic [SW-1:0] oTbState;
   logic          oBit;
   logic          oBitValid;
   logic          oLast;
   logic          oBusy;
   logic          oErr;

   modport master (
      output iStart, iLen, iValid, iA, iB, iDec,
      input  oReady, oBmA, oBmB, oPmInit, oAcsEn, oSmWe, oSmWAddr, oSmRe, oSmRAddr,
             oTbState, oBit, oBitValid, oLast, oBusy, oErr
   );

   modport slave (
      input  iStart, iLen, iValid, iA, iB, iDec,
      output oReady, oBmA, oBmB, oPmInit, oAcsEn, oSmWe, oSmWAddr, oSmRe, oSmRAddr,
             oTbState, oBit, oBitValid, oLast, oBusy, oErr
   );

endinterface

// File: rtl/viterbi_tb_unit.sv
// Block traceback: descending survivor reads, state shift register, tail suppression and last-bit flag.
module viterbi_tb_unit
   import viterbi_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW:0]   len,
   input  logic          dec,
   output logic          re,
   output logic [AW-1:0] raddr,
   output logic [SW-1:0] state,
   output logic          dec_bit,
   output logic          bit_valid,
   output logic          last
);

   logic          active_q;
   logic          ret_q;
   logic [AW-1:0] addr_q;
   logic [AW:0]   ret_cnt_q;
   logic [SW-1:0] state_q;
   logic [AW:0]   len_m1;

   assign len_m1 = len - 1'b1;

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q  <= 1'b0;
         ret_q     <= 1'b0;
         addr_q    <= '0;
         ret_cnt_q <= '0;
         state_q   <= '0;
      end else if (load) begin
         active_q  <= 1'b1;
         ret_q     <= 1'b0;
         addr_q    <= len_m1[AW-1:0];
         ret_cnt_q <= '0;
         state_q   <= '0;
      end else begin
         ret_q <= active_q;
         // Stop at address 0 instead of wrapping.
         if (active_q) begin
            if (addr_q == '0) active_q <= 1'b0;
            else              addr_q   <= addr_q - 1'b1;
         end
         if (ret_q) begin
            state_q   <= {state_q[SW-2:0], dec};
            ret_cnt_q <= ret_cnt_q + 1'b1;
         end
      end
   end

   assign re        = active_q;
   assign raddr     = addr_q;
   assign state     = state_q;
   assign bit_valid = ret_q && (ret_cnt_q >= (AW+1)'(TAIL));
   assign last      = ret_q && (ret_cnt_q == len_m1);
   assign dec_bit   = bit_valid && state_q[SW-1];

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi sequencing controller: frame FSM, step counter, BMU/ACS/survivor-write strobe pipeline.
module viterbi_ctrl
   import viterbi_pkg::*;
#(
   parameter int MAX_LEN = 4096,
   parameter int AW      = 12
) (
   input logic           iClk,
   input logic           iRst,
   viterbi_ctrl_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW:0]   len_q;
   logic [AW:0]   n_q;
   logic          drain_q;
   logic          bm_a_q, bm_b_q;
   logic          acs_q, we_q, err_q;
   logic [AW-1:0] addr1_q, waddr_q;
   logic          ready, pm_init, busy, tb_load, tb_last;
   logic          accept, len_ok;

   assign len_ok = (bus.iLen >= (AW+1)'(MIN_LEN)) && (bus.iLen <= (AW+1)'(MAX_LEN));
   assign accept = bus.iValid && (state_q == S_RUN);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      state_d = state_q;
      ready   = 1'b0;
      pm_init = 1'b0;
      busy    = 1'b1;
      tb_load = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (bus.iStart && len_ok) state_d = S_INIT;
         end
         S_INIT: begin
            pm_init = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            ready = 1'b1;
            if (accept && ((n_q + 1'b1) == len_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_q) begin
               tb_load = 1'b1;
               state_d = S_TB;
            end
         end
         S_TB: begin
            if (tb_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         n_q     <= '0;
         drain_q <= 1'b0;
         bm_a_q  <= 1'b0;
         bm_b_q  <= 1'b0;
         acs_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr1_q <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == S_DRAIN) && !drain_q;
         err_q   <= (state_q == S_IDLE) && bus.iStart && !len_ok;
         if ((state_q == S_IDLE) && bus.iStart && len_ok) len_q <= bus.iLen;

         if (state_q == S_INIT) n_q <= '0;
         else if (accept)       n_q <= n_q + 1'b1;

         // Two-stage pipeline: ACS strobe at t+1, survivor write of step t one cycle later.
         acs_q <= accept;
         if (accept) begin
            bm_a_q  <= bus.iA;
            bm_b_q  <= bus.iB;
            addr1_q <= n_q[AW-1:0];
         end
         we_q <= acs_q;
         if (acs_q) waddr_q <= addr1_q;
      end
   end

   viterbi_tb_unit #(.AW(AW)) u_tb (
      .clk       (iClk),
      .rst       (iRst),
      .load      (tb_load),
      .len       (len_q),
      .dec       (bus.iDec),
      .re        (bus.oSmRe),
      .raddr     (bus.oSmRAddr),
      .state     (bus.oTbState),
      .dec_bit   (bus.oBit),
      .bit_valid (bus.oBitValid),
      .last      (tb_last)
   );

   assign bus.oReady   = ready;
   assign bus.oPmInit  = pm_init;
   assign bus.oBusy    = busy;
   assign bus.oBmA     = bm_a_q;
   assign bus.oBmB     = bm_b_q;
   assign bus.oAcsEn   = acs_q;
   assign bus.oSmWe    = we_q;
   assign bus.oSmWAddr = waddr_q;
   assign bus.oErr     = err_q;
   assign bus.oLast    = tb_last;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed self-checking bench for viterbi_ctrl: drives frames, plays survivor memory, checks timing and bits.
module tb_viterbi_ctrl;
   import viterbi_pkg::*;

   localparam int MAX_LEN = 4096;
   localparam int AW      = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;

   viterbi_ctrl_if #(.AW(AW)) bus ();

   viterbi_ctrl #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   int          cyc = 0;
   bit          acc_now, acc_prev, a_prev, b_prev, acs_prev, re_prev, pm_prev, busy_prev;
   int          acc_cnt, acs_cnt, wr_idx, rd_idx, ret_idx, nvalid, nlast;
   int          last_acc_cyc, first_re_cyc, last_cyc, idle_cyc;
   int          err_cnt, strobe_cnt, busy_cnt, pm_cnt;
   logic [5:0]  m_state, state_at6;
   bit          first_bit, dec_next;
   logic [15:0] out_bits;
   int          exp_len;
   bit          dec_pat [MAX_LEN];
   logic [63:0] snap;

   // Observes one cycle at the falling edge and checks it against the bench's own expectations.
   task automatic monitor();
      acc_now = bus.iValid && bus.oReady && !rst;
      check("acs_timing", bus.oAcsEn, acc_prev);
      if (acc_prev) begin
         check("bm_a", bus.oBmA, a_prev);
         check("bm_b", bus.oBmB, b_prev);
      end
      check("we_timing", bus.oSmWe, acs_prev);
      if (pm_prev) check("ready_after_init", bus.oReady, 1'b1);
      if (bus.oPmInit) begin
         pm_cnt++;
         acc_cnt = 0; acs_cnt = 0; wr_idx = 0; rd_idx = 0; ret_idx = 0;
         nvalid = 0; nlast = 0; m_state = '0; out_bits = '0; first_re_cyc = 0;
      end
      if (acc_now)    begin acc_cnt++; last_acc_cyc = cyc; end
      if (bus.oAcsEn) acs_cnt++;
      if (bus.oSmWe) begin
         check("waddr", bus.oSmWAddr, wr_idx);
         wr_idx++;
      end
      if (re_prev) begin
         check("tb_state", bus.oTbState, m_state);
         check("bit_valid", bus.oBitValid, ret_idx >= TAIL);
         check("last", bus.oLast, ret_idx == exp_len - 1);
         if (ret_idx >= TAIL) check("bit", bus.oBit, m_state[5]);
         if (ret_idx == TAIL) begin
            state_at6 = bus.oTbState;
            first_bit = bus.oBit;
         end
         if (bus.oBitValid) begin
            nvalid++;
            out_bits = {out_bits[14:0], bus.oBit};
         end
         if (bus.oLast) begin
            nlast++;
            last_cyc = cyc;
         end
         m_state = {m_state[4:0], (ret_idx < MAX_LEN) ? dec_pat[ret_idx] : 1'b0};
         ret_idx++;
      end else begin
         check("no_bit_out", {bus.oBitValid, bus.oLast}, 2'b00);
      end
      dec_next = 1'b0;
      if (bus.oSmRe) begin
         if (rd_idx == 0) first_re_cyc = cyc;
         check("raddr", bus.oSmRAddr, exp_len - 1 - rd_idx);
         dec_next = (rd_idx < MAX_LEN) ? dec_pat[rd_idx] : 1'b0;
         rd_idx++;
      end
      if (bus.oErr) err_cnt++;
      if (bus.oAcsEn || bus.oSmWe || bus.oSmRe || bus.oPmInit) strobe_cnt++;
      if (bus.oBusy) busy_cnt++;
      if (busy_prev && !bus.oBusy) idle_cyc = cyc;
      snap = {bus.oReady, bus.oBmA, bus.oBmB, bus.oPmInit, bus.oAcsEn, bus.oSmWe, bus.oSmWAddr,
              bus.oSmRe, bus.oSmRAddr, bus.oTbState, bus.oBit, bus.oBitValid, bus.oLast,
              bus.oBusy, bus.oErr};
      acc_prev  = acc_now;
      a_prev    = bus.iA;
      b_prev    = bus.iB;
      acs_prev  = bus.oAcsEn && !rst;
      re_prev   = bus.oSmRe && !rst;
      pm_prev   = bus.oPmInit && !rst;
      busy_prev = bus.oBusy;
   endtask

   // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      bus.iDec = dec_next;
      cyc++;
   endtask

   task automatic try_illegal(input int len);
      int e0, s0, b0;
      e0 = err_cnt; s0 = strobe_cnt; b0 = busy_cnt;
      bus.iLen   = len[AW:0];
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      tick();
      tick();
      check($sformatf("err_pulse_len%0d", len), err_cnt - e0, 1);
      check($sformatf("no_strobe_len%0d", len), strobe_cnt - s0, 0);
      check($sformatf("no_busy_len%0d", len), busy_cnt - b0, 0);
   endtask

   task automatic run_frame(input int len, input bit gap, input bit zero_data, input bit noise);
      int sent, guard, e0, p0;
      exp_len = len; e0 = err_cnt; p0 = pm_cnt;
      bus.iLen   = len[AW:0];
      bus.iStart = 1'b1;
      tick();
      bus.iStart = noise;
      if (noise) bus.iLen = 13'd3;
      sent = 0; guard = 0;
      while (sent < len && guard < 3 * len + 10) begin
         bus.iValid = 1'b1;
         bus.iA     = zero_data ? 1'b0 : sent[0];
         bus.iB     = zero_data ? 1'b0 : (sent[1] ^ sent[0]);
         tick();
         guard++;
         if (acc_now) begin
            sent++;
            if (gap) begin
               bus.iValid = 1'b0;
               tick();
               guard++;
            end
         end
      end
      check("pairs_sent", sent, len);
      bus.iStart = 1'b0;
      // Keep offering pairs past the frame end; none may be taken.
      for (int i = 0; i < 3; i++) tick();
      bus.iValid = 1'b0;
      guard = 0;
      while (bus.oBusy && guard < len + 20) begin
         tick();
         guard++;
      end
      check("frame_done", bus.oBusy, 1'b0);
      tick();
      check("pm_init_once", pm_cnt - p0, 1);
      check("acc_cnt", acc_cnt, len);
      check("acs_cnt", acs_cnt, len);
      check("writes", wr_idx, len);
      check("reads", rd_idx, len);
      check("returns", ret_idx, len);
      check("valid_bits", nvalid, len - TAIL);
      check("last_once", nlast, 1);
      check("first_read_lat", first_re_cyc - last_acc_cyc, 3);
      check("tb_duration", last_cyc - first_re_cyc + 1, len + 1);
      check("end_to_end", last_cyc - last_acc_cyc, len + 3);
      check("idle_after_last", idle_cyc - last_cyc, 1);
      check("no_err_in_frame", err_cnt - e0, 0);
   endtask

   initial begin
      int sent, guard;
      bus.iStart = 1'b0;
      bus.iLen   = '0;
      bus.iValid = 1'b0;
      bus.iA     = 1'b0;
      bus.iB     = 1'b0;
      bus.iDec   = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("reset_outputs", snap, 64'd0);
      rst = 1'b0;
      tick();
      check("idle_outputs", snap, 64'd0);

      try_illegal(5);
      try_illegal(MAX_LEN + 1);
      try_illegal(6);
      try_illegal(0);

      // All-zero frame: 4 zero data bits.
      for (int i = 0; i < MAX_LEN; i++) dec_pat[i] = 1'b0;
      run_frame(10, 1'b0, 1'b1, 1'b0);
      check("zero_bits", out_bits[3:0], 4'b0000);

      // Known state walk 0->1->2->5->11->22->44, then 25, 51, 39.
      dec_pat[0] = 1; dec_pat[1] = 0; dec_pat[2] = 1; dec_pat[3] = 1; dec_pat[4] = 0;
      dec_pat[5] = 0; dec_pat[6] = 1; dec_pat[7] = 1; dec_pat[8] = 1; dec_pat[9] = 0;
      run_frame(10, 1'b0, 1'b0, 1'b0);
      check("walk_state_44", state_at6, 6'd44);
      check("walk_first_bit", first_bit, 1'b1);
      check("walk_bits", out_bits[3:0], 4'b1011);

      // Gapped input with stray iStart/illegal iLen held during the frame.
      for (int i = 0; i < MAX_LEN; i++) dec_pat[i] = 1'b0;
      run_frame(8, 1'b1, 1'b0, 1'b1);
      check("gap_bits", out_bits[1:0], 2'b00);

      // Minimum length: six 1s drive the state to 63, single data bit = 1.
      for (int i = 0; i < MAX_LEN; i++) dec_pat[i] = 1'b1;
      run_frame(7, 1'b0, 1'b0, 1'b0);
      check("min_state_63", state_at6, 6'd63);
      check("min_bit", out_bits[0], 1'b1);

      // Reset after 3 accepted pairs, then a clean frame.
      exp_len    = 10;
      bus.iLen   = 13'd10;
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      sent = 0; guard = 0;
      while (sent < 3 && guard < 20) begin
         bus.iValid = 1'b1;
         bus.iA     = 1'b1;
         bus.iB     = 1'b1;
         tick();
         guard++;
         if (acc_now) sent++;
      end
      check("rst_pairs_sent", sent, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.iValid = 1'b0;
      tick();
      check("mid_run_reset", snap, 64'd0);
      for (int i = 0; i < MAX_LEN; i++) dec_pat[i] = 1'b0;
      run_frame(10, 1'b0, 1'b0, 1'b0);

      // Maximum frame.
      for (int i = 0; i < MAX_LEN; i++) dec_pat[i] = (i % 3 == 0);
      run_frame(MAX_LEN, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Sequencing controller for the 802.11a K=7, rate-1/2 hard-decision Viterbi decoder in the RX chain. It accepts one coded bit pair (A,B) per handshake and forwards it to the branch metric unit. It pulses the add-compare-select (ACS) stage and generates survivor-memory write addresses. At frame end it runs a block traceback from state 0 and emits decoded data bits in reverse order, with the 6 tail bits dropped.

## Interface
- `MAX_LEN`, 4096: maximum frame length in trellis steps, tail included; this is the survivor-memory depth.
- `AW`, 12: survivor-memory address width; requires 2^AW ≥ MAX_LEN.
- `iClk` in 1: single clock.
- `iRst` in 1: reset, synchronous and active-high.
- `iStart` in 1: frame start pulse; sampled only in IDLE.
- `iLen` in AW+1: frame length in steps, tail included; latched on `iStart`.
- `iValid` in 1: coded pair valid.
- `iA`, `iB` in 1 each: coded bits A and B.
- `oReady` out 1: controller accepts a pair this cycle.
- `oBmA`, `oBmB` out 1 each: registered pair, driven to the BMU inputs.
- `oPmInit` out 1: path-metric init pulse (state 0 → 0, others → max).
- `oAcsEn` out 1: ACS update strobe.
- `oSmWe` out 1: survivor write enable.
- `oSmWAddr` out AW: survivor write address.
- `oSmRe` out 1: survivor read enable.
- `oSmRAddr` out AW: survivor read address.
- `oTbState` out 6: current traceback state; the external mux uses it to select the decision bit.
- `iDec` in 1: selected decision bit, valid one cycle after `oSmRe`.
- `oBit` out 1: decoded bit.
- `oBitValid` out 1: `oBit` is valid.
- `oLast` out 1: marks the final decoded bit (data index 0).
- `oBusy` out 1: high when state ≠ IDLE.
- `oErr` out 1: one-cycle pulse on an illegal `iLen`.

## Operation
- FSM states: IDLE → INIT → RUN → DRAIN → TB → IDLE.
- **IDLE**
  - On `iStart` with 7 ≤ `iLen` ≤ MAX_LEN: latch `iLen`, go to INIT.
  - On `iStart` with any other `iLen`: pulse `oErr`, stay in IDLE.
- **INIT** (1 cycle): assert `oPmInit`, clear the step counter `n`, go to RUN.
- **RUN**
  - `oReady` = 1.
  - On each `iValid` & `oReady`: register `iA`/`iB` into `oBmA`/`oBmB`, schedule `oAcsEn`, schedule a survivor write at address `n`, then increment `n`.
  - When `n` reaches `iLen`, go to DRAIN.
  - Pairs beyond `iLen` are never accepted, because `oReady` drops in the same cycle the count completes.
- **DRAIN** (2 cycles): the last ACS strobe and the last survivor write retire. Then `oTbState` = 0 (the encoder is tail-terminated) and the FSM goes to TB.
- **TB**
  - Reads are issued at `oSmRAddr` = `iLen`−1 down to 0, one per cycle, pipelined.
  - On each returned `iDec`: output bit = `oTbState[5]`, then `oTbState` ← {`oTbState[4:0]`, `iDec`}.
  - The first 6 outputs are tail bits: `oBitValid` stays low for them.
  - The remaining `iLen`−6 bits are emitted with `oBitValid` = 1; `oLast` is asserted with the final one.
  - The FSM returns to IDLE the cycle after `oLast`.
- `iStart` outside IDLE is ignored.
- `iValid` outside RUN is ignored; `iA`/`iB` are don't-care then.
- `iRst` mid-frame aborts on the next edge. There is no partial output and the survivor memory contents become don't-care.

## Timing
- After reset, every output is 0; `oTbState` = 0; FSM = IDLE.
- Handshake accepted at cycle t:
  - `oBmA`/`oBmB` and `oAcsEn` are valid at t+1; the BMU and ACS path is combinational at that point.
  - `oSmWe` at t+2, with `oSmWAddr` = the step index.
- Throughput in RUN: 1 pair per cycle.
- `oPmInit` occurs exactly one cycle before the first cycle `oReady` can be high.
- Traceback:
  - First `oSmRe` in the cycle after DRAIN.
  - `iDec` for address k arrives one cycle after the read of k.
  - Traceback duration = `iLen`+1 cycles.
- End-to-end: last accepted pair → `oLast` = 2 + `iLen` + 1 cycles.
- `oSmRAddr` never wraps: the traceback stops at address 0.
- `oSmWAddr` never exceeds `iLen`−1.

## Structure
- Package `viterbi_pkg` holds:
  - K = 7, N_STATES = 64, TAIL = 6;
  - the FSM state enum (IDLE, INIT, RUN, DRAIN, TB);
  - the `oPmInit` max-metric constant.
- One sub-module, `viterbi_tb_unit`, holds:
  - the read-address down-counter;
  - the state shift register;
  - tail suppression and `oLast` generation.
- The top level holds the FSM, the step counter and the handshake/strobe pipeline.

## Test plan
- **Illegal length:** `iLen`=5, then `iLen`=MAX_LEN+1 → `oErr` pulses each time, `oBusy` stays 0, no strobes.
- **All-zero frame:** `iLen`=10, all pairs (0,0), `iDec` driven 0 → exactly 10 `oAcsEn` and 10 writes at addresses 0..9. Reads 9..0; 4 bits 0 with `oBitValid`; `oLast` on the 4th.
- **Known state walk:** `iDec` sequence 1,0,1,1,0,0 for the 6 tail steps → `oTbState` walks 0→1→2→5→11→22→44. The first valid output bit equals bit 5 of 44 = 1.
- **Gapped input:** `iValid` toggled every other cycle, `iLen`=8 → still 8 acceptances, then DRAIN and traceback. Timing rule: `oAcsEn` one cycle after each accepted pair.
- **Reset mid-RUN:** `iRst` after 3 pairs → next cycle all outputs 0 and IDLE. A new `iStart` then runs cleanly with a fresh `oPmInit`.
- **Max frame:** `iLen`=MAX_LEN → write addresses 0..MAX_LEN−1, read addresses descend to 0 with no wrap, MAX_LEN−6 valid bits, `oLast` once.
